// File: rtl/l2_cache_plru_pkg.sv
// Shared L2 cache definitions: geometry, PLRU tree type and sequencer states.
// Imported by the PLRU replacement unit, its bus interface and tree logic.
package cache_def;

  localparam int WAYS      = 8;
  localparam int DEPTH     = 256;
  localparam int INDEX     = 8;
  localparam int INDEX_WAY = 3;

  // b0 is the root, b1/b2 the level-1 nodes, b3..b6 the leaves.
  typedef logic [6:0] plru_tree_t;

  typedef enum logic {
    PLRU_INIT,
    PLRU_RUN
  } plru_state_e;

endpackage

// File: rtl/l2_cache_plru_if.sv
// Request/update/flush bus between the L2 controller (master) and the PLRU
// replacement unit (slave).
interface l2_cache_plru_if;
  import cache_def::*;

  logic                 flush_i;
  logic                 req_i;
  logic [INDEX-1:0]     req_index_i;
  logic                 upd_i;
  logic [INDEX-1:0]     upd_index_i;
  logic [INDEX_WAY-1:0] upd_way_i;
  logic [WAYS-1:0]      valid_vec_i;
  logic [INDEX_WAY-1:0] victim_way_o;
  logic                 victim_valid_o;
  logic                 init_busy_o;

  modport master (
    output flush_i, req_i, req_index_i, upd_i, upd_index_i, upd_way_i, valid_vec_i,
    input  victim_way_o, victim_valid_o, init_busy_o
  );

  modport slave (
    input  flush_i, req_i, req_index_i, upd_i, upd_index_i, upd_way_i, valid_vec_i,
    output victim_way_o, victim_valid_o, init_busy_o
  );

endinterface

// File: rtl/l2_plru_tree_logic.sv
// Combinational 8-way tree-PLRU: walks a tree to its victim way and computes
// the tree after an access to way_i (path bits point away from way_i).
module l2_plru_tree_logic
  import cache_def::*;
(
  input  plru_tree_t           tree_i,
  input  logic [INDEX_WAY-1:0] way_i,
  output logic [INDEX_WAY-1:0] victim_o,
  output plru_tree_t           tree_o
);

  logic       root_bit;
  logic       mid_bit;
  logic [1:0] leaf_sel;
  logic [3:0] leaves;

  assign root_bit = tree_i[0];
  assign mid_bit  = root_bit ? tree_i[2] : tree_i[1];
  assign leaf_sel = {root_bit, mid_bit};
  assign leaves   = tree_i[6:3];
  assign victim_o = {root_bit, mid_bit, leaves[leaf_sel]};

  assign tree_o[0] = ~way_i[2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_mid
      assign tree_o[1+gi] = (way_i[2] == 1'(gi)) ? ~way_i[1] : tree_i[1+gi];
    end
    for (gi = 0; gi < 4; gi++) begin : g_leaf
      assign tree_o[3+gi] = (way_i[2:1] == 2'(gi)) ? ~way_i[0] : tree_i[3+gi];
    end
  endgenerate

endmodule

// File: rtl/l2_cache_plru.sv
// Per-set tree pseudo-LRU victim selector for the 8-way L2, with a self-clearing
// init/flush sequencer. Optional macro L2_PLRU_INVALID_FIRST_EN: invalid ways win.
module l2_cache_plru
  import cache_def::*;
#(
  parameter int P_WAYS      = WAYS,
  parameter int P_DEPTH     = DEPTH,
  parameter int P_INDEX     = INDEX,
  parameter int P_INDEX_WAY = INDEX_WAY
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  l2_cache_plru_if.slave  bus
);

  generate
    if (P_WAYS != 8) begin : g_ways_chk
      $error("l2_cache_plru: tree logic supports exactly 8 ways");
    end
    if (P_INDEX != $clog2(P_DEPTH)) begin : g_index_chk
      $error("l2_cache_plru: INDEX must equal clog2(DEPTH)");
    end
    if (P_INDEX_WAY != 3) begin : g_way_chk
      $error("l2_cache_plru: INDEX_WAY must be 3");
    end
  endgenerate

  localparam logic [P_INDEX-1:0] CNT_LAST = P_INDEX'(P_DEPTH - 1);

  plru_state_e            state_q, state_d;
  logic [P_INDEX-1:0]     cnt_q, cnt_d;
  logic [P_INDEX_WAY-1:0] victim_q, victim_d;
  logic                   vvalid_q, vvalid_d;
  logic                   busy_q, busy_d;

  plru_tree_t             plru_q [P_DEPTH];

  plru_tree_t             upd_tree_cur, upd_tree_new;
  plru_tree_t             req_tree_raw, req_tree;
  plru_tree_t             lookup_tree_unused;
  logic [P_INDEX_WAY-1:0] upd_victim_unused;
  logic [P_INDEX_WAY-1:0] tree_victim, sel_victim;
  logic                   run, upd_fire;
  logic                   mem_we;
  logic [P_INDEX-1:0]     mem_waddr;
  plru_tree_t             mem_wdata;

  assign run          = (state_q == PLRU_RUN);
  assign upd_fire     = run & bus.upd_i & ~bus.flush_i;
  assign upd_tree_cur = plru_q[bus.upd_index_i];
  assign req_tree_raw = plru_q[bus.req_index_i];

  // A same-set update in this cycle must be visible to the lookup.
  assign req_tree = (upd_fire && (bus.upd_index_i == bus.req_index_i)) ? upd_tree_new
                                                                      : req_tree_raw;

  l2_plru_tree_logic u_upd_tree (
    .tree_i   (upd_tree_cur),
    .way_i    (bus.upd_way_i),
    .victim_o (upd_victim_unused),
    .tree_o   (upd_tree_new)
  );

  l2_plru_tree_logic u_lookup_tree (
    .tree_i   (req_tree),
    .way_i    ('0),
    .victim_o (tree_victim),
    .tree_o   (lookup_tree_unused)
  );

`ifdef L2_PLRU_INVALID_FIRST_EN
  always_comb begin
    sel_victim = tree_victim;
    if (!(&bus.valid_vec_i)) begin
      for (int i = P_WAYS - 1; i >= 0; i--) begin
        if (!bus.valid_vec_i[i]) sel_victim = P_INDEX_WAY'(i);
      end
    end
  end
`else
  logic valid_vec_unused;
  assign valid_vec_unused = ^bus.valid_vec_i;
  assign sel_victim       = tree_victim;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    victim_d  = victim_q;
    vvalid_d  = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = bus.upd_index_i;
    mem_wdata = upd_tree_new;
    if (bus.flush_i) begin
      state_d = PLRU_INIT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        PLRU_INIT: begin
          mem_we    = 1'b1;
          mem_waddr = cnt_q;
          mem_wdata = '0;
          if (cnt_q == CNT_LAST) begin
            state_d = PLRU_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PLRU_RUN: begin
          mem_we = upd_fire;
          if (bus.req_i) begin
            vvalid_d = 1'b1;
            victim_d = sel_victim;
          end
        end
        default: begin
          state_d = PLRU_INIT;
          cnt_d   = '0;
        end
      endcase
    end
    busy_d = (state_d == PLRU_INIT);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= PLRU_INIT;
      cnt_q    <= '0;
      victim_q <= '0;
      vvalid_q <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      victim_q <= victim_d;
      vvalid_q <= vvalid_d;
      busy_q   <= busy_d;
    end
  end

  // Tree storage has no reset; the init sequence clears it after every reset.
  always_ff @(posedge clk_i) begin
    if (mem_we && rst_ni) plru_q[mem_waddr] <= mem_wdata;
  end

  assign bus.victim_way_o   = victim_q;
  assign bus.victim_valid_o = vvalid_q;
  assign bus.init_busy_o    = busy_q;

endmodule

// File: tb/tb_l2_cache_plru.sv
// Directed self-checking bench for l2_cache_plru: init/flush timing, tree
// victim walk, update, same-cycle forwarding and the invalid-first option.
module tb_l2_cache_plru;
  import cache_def::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   n;
  logic seen_valid;

  l2_cache_plru_if bus ();

  l2_cache_plru dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic wait_init(output int cycles);
    cycles = 0;
    while (bus.init_busy_o === 1'b1 && cycles < 1000) begin
      tick();
      cycles++;
    end
  endtask

  task automatic do_req(input string tag, input logic [INDEX-1:0] idx,
                        input logic [INDEX_WAY-1:0] exp);
    bus.req_i       = 1'b1;
    bus.req_index_i = idx;
    tick();
    bus.req_i = 1'b0;
    check({tag, "_valid"}, 32'(bus.victim_valid_o), 32'd1);
    check(tag, 32'(bus.victim_way_o), 32'(exp));
  endtask

  task automatic do_upd(input logic [INDEX-1:0] idx, input logic [INDEX_WAY-1:0] way);
    bus.upd_i       = 1'b1;
    bus.upd_index_i = idx;
    bus.upd_way_i   = way;
    tick();
    bus.upd_i = 1'b0;
  endtask

  task automatic do_both(input string tag, input logic [INDEX-1:0] uidx,
                         input logic [INDEX_WAY-1:0] way, input logic [INDEX-1:0] ridx,
                         input logic [INDEX_WAY-1:0] exp);
    bus.upd_i       = 1'b1;
    bus.upd_index_i = uidx;
    bus.upd_way_i   = way;
    do_req(tag, ridx, exp);
    bus.upd_i = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.flush_i     = 1'b0;
    bus.req_i       = 1'b0;
    bus.req_index_i = '0;
    bus.upd_i       = 1'b0;
    bus.upd_index_i = '0;
    bus.upd_way_i   = '0;
    bus.valid_vec_i = '1;
    tick();
    tick();
    check("rst_busy", 32'(bus.init_busy_o), 32'd1);
    check("rst_valid", 32'(bus.victim_valid_o), 32'd0);
    check("rst_way", 32'(bus.victim_way_o), 32'd0);
    rst_n = 1'b1;

    // Requests during the clear are dropped.
    bus.req_i  = 1'b1;
    seen_valid = 1'b0;
    n = 0;
    while (bus.init_busy_o === 1'b1 && n < 1000) begin
      if (bus.victim_valid_o !== 1'b0) seen_valid = 1'b1;
      tick();
      n++;
    end
    if (bus.victim_valid_o !== 1'b0) seen_valid = 1'b1;
    bus.req_i = 1'b0;
    check("init_len", 32'(n), 32'd256);
    check("init_req_drop", 32'(seen_valid), 32'd0);

    do_req("idx5_fresh", 8'd5, 3'd0);
    tick();
    check("valid_idle", 32'(bus.victim_valid_o), 32'd0);

    do_upd(8'd5, 3'd0);
    do_req("idx5_after_w0", 8'd5, 3'd4);
    do_upd(8'd5, 3'd4);
    do_req("idx5_after_w4", 8'd5, 3'd2);
    do_req("idx6_untouched", 8'd6, 3'd0);
    do_req("idx5_no_side_effect", 8'd5, 3'd2);

    for (int w = 0; w < 8; w++) do_upd(8'd9, 3'(w));
    do_req("idx9_all_ways", 8'd9, 3'd0);

    do_both("fwd_same_idx", 8'd3, 3'd0, 8'd3, 3'd4);
    do_both("fwd_diff_idx", 8'd3, 3'd1, 8'd7, 3'd0);
    do_req("idx3_after_w1", 8'd3, 3'd4);

    // Flush, with an update late in the clear that must be ignored.
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    check("flush_busy", 32'(bus.init_busy_o), 32'd1);
    n = 0;
    while (bus.init_busy_o === 1'b1 && n < 1000) begin
      bus.upd_i       = (n == 200);
      bus.upd_index_i = 8'd0;
      bus.upd_way_i   = 3'd0;
      tick();
      n++;
    end
    bus.upd_i = 1'b0;
    check("flush_len", 32'(n), 32'd256);
    do_req("flush_idx0", 8'd0, 3'd0);
    do_req("flush_idx3", 8'd3, 3'd0);
    do_req("flush_idx5", 8'd5, 3'd0);
    do_req("flush_idx9", 8'd9, 3'd0);

    // A second flush mid-clear restarts the full count.
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    repeat (100) tick();
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    wait_init(n);
    check("reflush_len", 32'(n), 32'd256);

    // Flush wins over a simultaneous update.
    bus.flush_i     = 1'b1;
    bus.upd_i       = 1'b1;
    bus.upd_index_i = 8'd20;
    bus.upd_way_i   = 3'd0;
    tick();
    bus.flush_i = 1'b0;
    bus.upd_i   = 1'b0;
    wait_init(n);
    check("flush_upd_len", 32'(n), 32'd256);
    do_req("flush_upd_idx20", 8'd20, 3'd0);

    bus.valid_vec_i = 8'b1111_0111;
`ifdef L2_PLRU_INVALID_FIRST_EN
    do_req("invalid_first", 8'd5, 3'd3);
`else
    do_req("invalid_ignored", 8'd5, 3'd0);
`endif
    bus.valid_vec_i = '1;
    do_upd(8'd5, 3'd0);
    do_req("all_valid_tree", 8'd5, 3'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/l2_cache_plru.md
Name: l2_cache_plru

Overview:
- Tree pseudo-LRU replacement unit for the 8-way L2 cache.
- Sits directly upstream of the L2 tag store and supplies the way address used on a miss fill (the tag store's address_way_i input).
- Keeps one 7-bit PLRU tree per set; updated by the controller on every hit and fill.
- Has a self-clearing init/flush sequencer.

Parameters:
- WAYS, 8, associativity; tree logic is fixed to 8 (elaboration error otherwise).
- DEPTH, 256, number of sets.
- INDEX, 8, set-index width; must equal clog2(DEPTH).
- INDEX_WAY, 3, way-address width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; one clock, synchronous, active-low.
- flush_i  in  1  pulse; restarts the clear sequence.
- req_i  in  1  victim lookup request.
- req_index_i  in  INDEX  set for the lookup.
- upd_i  in  1  access update (hit or fill).
- upd_index_i  in  INDEX  set being updated.
- upd_way_i  in  INDEX_WAY  way accessed.
- valid_vec_i  in  WAYS  valid bits of req_index_i set (used only with the optional feature).
- victim_way_o  out  INDEX_WAY  registered victim way.
- victim_valid_o  out  1  victim_way_o valid this cycle.
- init_busy_o  out  1  clear sequence running.

Behaviour:
- Storage: plru[DEPTH], 7 bits each (b0 root; b1/b2 level 1; b3..b6 leaves).
- Victim walk:
  - b0=0 goes to b1 (ways 0-3), b0=1 goes to b2 (ways 4-7).
  - b1 selects b3/b4; b2 selects b5/b6.
  - Leaf bit selects the even (0) or odd (1) way, i.e. way = {b0, level-1 bit, leaf bit}.
- Update for way w: bits on w's path are set to point away from w.
  - root = ~w[2]; level-1 node on w's side = ~w[1]; leaf on w's side = ~w[0].
  - Bits off the path are unchanged.
- FSM states:
  - INIT: counter starts at 0 and writes 0 to plru[counter] each cycle. After set DEPTH-1 go to RUN. Duration is exactly DEPTH cycles; init_busy_o=1.
  - RUN: normal operation; init_busy_o=0.
  - flush_i in any state goes to INIT with counter=0. A flush during INIT restarts the count from 0.
- Reset (rst_ni=0 at a clock edge): state=INIT, counter=0, victim_way_o=0, victim_valid_o=0, init_busy_o=1. Reset mid-sequence restarts the clear.
- Lookup latency 1:
  - req_i in RUN at cycle N gives victim_way_o and victim_valid_o=1 at cycle N+1.
  - victim_valid_o is 0 otherwise, including for any req_i during INIT (request dropped, no response).
- Update: upd_i in RUN writes the updated tree at the clock edge. upd_i during INIT is ignored.
- Same-cycle forwarding: if req_i and upd_i arrive together with req_index_i == upd_index_i, the victim is computed from the post-update tree.
- Lookup has no side effect on the tree; the controller issues upd_i on the fill.
- Simultaneous flush_i and upd_i: flush wins, update dropped.
- Index widths match exactly; no wrap logic beyond the counter reaching DEPTH-1.

Optional Feature:
- Macro: L2_PLRU_INVALID_FIRST_EN.
- Defined: if valid_vec_i is not all ones, the victim is the lowest-numbered way with valid_vec_i=0, overriding the tree. Sampled with req_i; same 1-cycle latency.
- Undefined: valid_vec_i is unused, and the victim always comes from the tree.

Decomposition:
- Shared package cache_def carries:
  - WAYS, DEPTH, INDEX, INDEX_WAY.
  - New typedef plru_tree_t (logic [6:0]).
  - State enum plru_state_e {PLRU_INIT, PLRU_RUN}.
- One natural sub-module: l2_plru_tree_logic, purely combinational.
  - Inputs: 7-bit tree and a way.
  - Outputs: victim way and updated tree.
  - Instantiated twice: lookup path and update path.

Test Plan:
- Reset with DEPTH=256 → init_busy_o=1 for exactly 256 cycles, then 0. req_i during busy → victim_valid_o stays 0.
- After init, req index 5 → next cycle victim_way_o=0, victim_valid_o=1.
- upd index 5 way 0, then req index 5 → victim 4. Then upd way 4, req → victim 2. Index 6 still → victim 0.
- upd ways 0..7 in order on index 9 → subsequent req → victim 0.
- Same cycle upd index 3 way 0 and req index 3 → victim 4 (forwarded). Same cycle with different index 7 → victim 0.
- flush_i after updates → 256 busy cycles, then every set returns victim 0.
- With L2_PLRU_INVALID_FIRST_EN: req with valid_vec_i=8'b11110111 → victim 3. With all ones → tree victim.
